nibble_serial_add_ctrl: RTL
===========================

NIBBLE_SERIAL_ADD_CTRL -- requirements
Module: nibble_serial_add_ctrl

Interface
REQ-001 The block SHALL have parameter N_NIB, default 4, meaning the number of 4-bit nibbles per operand; operand width W = 4*N_NIB.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-high; the ports are named clk and rst.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 in_valid  input  1  operands and mode are valid.
REQ-006 in_ready  output  1  block can accept an operation.
REQ-007 a  input  W  first operand.
REQ-008 b  input  W  second operand.
REQ-009 cin  input  1  carry-in for add mode; ignored when sub=1.
REQ-010 sub  input  1  1 = compute a-b, 0 = compute a+b+cin.
REQ-011 out_valid  output  1  result fields are valid.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 sum  output  W  result.
REQ-014 cout  output  1  carry out of the MSB nibble (for sub, 1 = no borrow).
REQ-015 ovf  output  1  signed two's-complement overflow.
REQ-016 zero  output  1  sum == 0.
REQ-017 busy  output  1  high in RUN or DONE.

Function
REQ-018 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-019 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-020 In IDLE, in_valid&in_ready SHALL capture a, b xor {W{sub}}, and carry register = sub ? 1 : cin, clear the nibble index, and go to RUN.
REQ-021 In RUN, each cycle SHALL add nibble[idx] of the captured a and effective b with the carry register through one 4-bit adder, write the 4-bit result into sum[idx], update the carry register with its carry-out, and increment idx.
REQ-022 When idx == N_NIB-1 is processed, the FSM SHALL go to DONE; latency from the accept edge to out_valid high SHALL be exactly N_NIB cycles.
REQ-023 cout SHALL equal the final carry register.
REQ-024 ovf SHALL be (a[W-1] == beff[W-1]) && (sum[W-1] != a[W-1]).
REQ-025 zero SHALL be 1 iff all W sum bits are 0.
REQ-026 In DONE, sum, cout, ovf and zero SHALL hold stable while out_valid=1 and out_ready=0.
REQ-027 out_valid&out_ready SHALL return the FSM to IDLE; no new operation is accepted in that same cycle (one bubble).
REQ-028 in_valid SHALL be ignored outside IDLE; a, b, cin and sub SHALL be sampled only on the accept edge.
REQ-029 All arithmetic SHALL wrap modulo 2^W; no state SHALL depend on the operand values beyond the current operation.

Reset
REQ-030 rst SHALL force IDLE, idx=0, carry=0, sum=0, cout=0, ovf=0, and zero=1 (derived from sum=0); this gives out_valid=0, in_ready=1 and busy=0.
REQ-031 rst asserted mid-RUN or in DONE SHALL abort the operation with no out_valid pulse; the first accept after release starts cleanly.

Structure
REQ-032 A shared package SHALL hold the FSM state enum (IDLE/RUN/DONE) and the constant NIB_W=4.
REQ-033 The block SHALL instantiate exactly one 4-bit carry-lookahead adder sub-module, CLA_Adder (ports a, b, cin, sum, cout), as its only arithmetic resource.

Verification
REQ-034 Test: 0x1234+0x4321, cin=0 -> after 4 cycles sum=0x5555, cout=0, ovf=0, zero=0.
REQ-035 Test: 0xFFFF+0x0001, cin=0 -> sum=0x0000, cout=1, zero=1, ovf=0.
REQ-036 Test: sub 0x0005-0x0007 -> sum=0xFFFE, cout=0, ovf=0; sub 0x8000-0x0001 -> sum=0x7FFF, ovf=1.
REQ-037 Test: 0x7FFF+0x0001 -> sum=0x8000, ovf=1; then hold out_ready=0 for 5 cycles -> out_valid and outputs stable, in_ready=0.
REQ-038 Test: assert rst for 1 cycle at RUN idx=2 -> out_valid never asserts, in_ready=1 next cycle; a following 0x0001+0x0001 gives 0x0002.
REQ-039 Test: back-to-back in_valid held high with out_ready=1 -> one result every N_NIB+2 cycles, results in order.

Source files
------------

// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared types and constants for the nibble-serial adder controller.
package nibble_serial_add_ctrl_pkg;

  localparam int unsigned NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_serial_add_ctrl_cla.sv
// 4-bit carry-lookahead adder; the sole arithmetic resource of the controller.
module CLA_Adder
  import nibble_serial_add_ctrl_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] sum,
  output logic             cout
);

  logic [NIB_W-1:0] w_g;
  logic [NIB_W-1:0] w_p;
  logic [NIB_W:0]   w_c;

  assign w_g = a & b;
  assign w_p = a ^ b;

  // Fully expanded lookahead carries, no ripple chain.
  assign w_c[0] = cin;
  assign w_c[1] = w_g[0] | (w_p[0] & cin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & cin);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & cin);

  assign sum  = w_p ^ w_c[NIB_W-1:0];
  assign cout = w_c[NIB_W];

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial add/subtract controller: one 4-bit CLA slice reused over N_NIB cycles
// with valid/ready handshakes on both sides.
module nibble_serial_add_ctrl
  import nibble_serial_add_ctrl_pkg::*;
#(
  parameter int unsigned N_NIB = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NIB_W*N_NIB-1:0] a,
  input  logic [NIB_W*N_NIB-1:0] b,
  input  logic                   cin,
  input  logic                   sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NIB_W*N_NIB-1:0] sum,
  output logic                   cout,
  output logic                   ovf,
  output logic                   zero,
  output logic                   busy
);

  localparam int unsigned W     = NIB_W * N_NIB;
  localparam int unsigned IDX_W = (N_NIB > 1) ? $clog2(N_NIB) : 1;

  state_t             r_state;
  logic [IDX_W-1:0]   r_idx;
  logic [W-1:0]       r_a;
  logic [W-1:0]       r_b;
  logic               r_carry;
  logic [W-1:0]       r_sum;
  logic               r_ovf;
  logic               r_zero;

  logic [NIB_W-1:0]   w_a_nib;
  logic [NIB_W-1:0]   w_b_nib;
  logic [NIB_W-1:0]   w_nib_sum;
  logic               w_nib_cout;
  logic [W-1:0]       w_sum_next;
  logic               w_last;

  assign w_a_nib = r_a[r_idx*NIB_W +: NIB_W];
  assign w_b_nib = r_b[r_idx*NIB_W +: NIB_W];
  assign w_last  = (r_idx == IDX_W'(N_NIB - 1));

  CLA_Adder u_cla (
    .a    (w_a_nib),
    .b    (w_b_nib),
    .cin  (r_carry),
    .sum  (w_nib_sum),
    .cout (w_nib_cout)
  );

  // Running sum with the current nibble merged in; used for the final flags.
  always_comb begin
    w_sum_next = r_sum;
    w_sum_next[r_idx*NIB_W +: NIB_W] = w_nib_sum;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b ^ {W{sub}};
            r_carry <= sub ? 1'b1 : cin;
            r_idx   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_sum   <= w_sum_next;
          r_carry <= w_nib_cout;
          r_idx   <= r_idx + IDX_W'(1);
          if (w_last) begin
            r_ovf   <= (r_a[W-1] == r_b[W-1]) && (w_sum_next[W-1] != r_a[W-1]);
            r_zero  <= ~|w_sum_next;
            r_state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign sum       = r_sum;
  assign cout      = r_carry;
  assign ovf       = r_ovf;
  assign zero      = r_zero;

endmodule
